// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder and the multiply/divide engine.
package alu_pkg;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_AND   = 3'b101;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    localparam logic [3:0] GOUT_AND = 4'b0000;
    localparam logic [3:0] GOUT_OR  = 4'b0001;
    localparam logic [3:0] GOUT_ADD = 4'b0010;
    localparam logic [3:0] GOUT_SUB = 4'b0110;
    localparam logic [3:0] GOUT_SLT = 4'b0111;
    localparam logic [3:0] GOUT_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } md_state_e;

    typedef enum logic {
        MD_MULTU,
        MD_DIVU
    } md_op_e;

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle,
// results written to the architectural HI/LO registers.
module muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e        state, state_nx;
    md_op_e           op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] m_q, up_q, dn_q;
    logic [WIDTH-1:0] up_nx, dn_nx;
    logic [WIDTH:0]   sum, trial;
    logic             div0, accept;

    assign div0   = (op == MD_DIVU) && (b == '0);
    assign accept = start && (state != ST_RUN);
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = div0 ? ST_DONE : ST_RUN;
            ST_RUN:  if (cnt == LAST) state_nx = ST_DONE;
            ST_DONE: begin
                if (start) state_nx = div0 ? ST_DONE : ST_RUN;
                else       state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // up_q is the product high half / partial remainder; dn_q the multiplier / dividend-quotient
    always_comb begin
        sum   = {1'b0, up_q} + (dn_q[0] ? {1'b0, m_q} : '0);
        trial = {up_q, dn_q[WIDTH-1]} - {1'b0, m_q};
        up_nx = up_q;
        dn_nx = dn_q;
        if (op_q == MD_MULTU) begin
            up_nx = sum[WIDTH:1];
            dn_nx = {sum[0], dn_q[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            up_nx = trial[WIDTH-1:0];
            dn_nx = {dn_q[WIDTH-2:0], 1'b1};
        end else begin
            up_nx = {up_q[WIDTH-2:0], dn_q[WIDTH-1]};
            dn_nx = {dn_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= MD_MULTU;
            cnt  <= '0;
            m_q  <= '0;
            up_q <= '0;
            dn_q <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (accept) begin
            op_q <= op;
            cnt  <= '0;
            m_q  <= (op == MD_MULTU) ? a : b;
            dn_q <= (op == MD_MULTU) ? b : a;
            up_q <= '0;
            if (div0) begin
                hi <= a;
                lo <= '1;
            end
        end else if (state == ST_RUN) begin
            cnt  <= cnt + 1'b1;
            up_q <= up_nx;
            dn_q <= dn_nx;
            if (cnt == LAST) begin
                hi <= up_nx;
                lo <= dn_nx;
            end
        end
    end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus muldiv request detection, pipeline stall and HI/LO readout.
module alu_ctrl_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       aluop,
    input  logic [5:0]       funct,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       gout,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hilo_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic   is_r, req_mul, req_div, req_mf, start;
    md_op_e op_sel;

    assign is_r    = valid_in && (aluop == ALUOP_RTYPE);
    assign req_mul = is_r && (funct == FUNCT_MULTU);
    assign req_div = is_r && (funct == FUNCT_DIVU);
    assign req_mf  = is_r && ((funct == FUNCT_MFHI) || (funct == FUNCT_MFLO));
    assign op_sel  = req_div ? MD_DIVU : MD_MULTU;

    // Requests presented while the engine iterates are held off, never queued
    assign start = (req_mul || req_div) && !busy;
    assign stall = busy && (req_mul || req_div || req_mf);

    assign hilo_out = ((aluop == ALUOP_RTYPE) && (funct == FUNCT_MFHI)) ? hi : lo;

    always_comb begin
        gout = GOUT_ADD;
        case (aluop)
            ALUOP_SUB: gout = GOUT_SUB;
            ALUOP_AND: gout = GOUT_AND;
            ALUOP_OR:  gout = GOUT_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_SUB: gout = GOUT_SUB;
                    FUNCT_AND: gout = GOUT_AND;
                    FUNCT_OR:  gout = GOUT_OR;
                    FUNCT_SLT: gout = GOUT_SLT;
                    FUNCT_NOR: gout = GOUT_NOR;
                    default:   gout = GOUT_ADD;
                endcase
            end
            default: gout = GOUT_ADD;
        endcase
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op_sel),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Bench for alu_ctrl_muldiv at WIDTH=8 and WIDTH=32 against a plain-arithmetic reference.
module tb_alu_ctrl_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  aluop8, aluop32;
    logic [5:0]  funct8, funct32;
    logic        valid8, valid32;
    logic [7:0]  a8, b8, hilo8, hi8, lo8;
    logic [31:0] a32, b32, hilo32, hi32, lo32;
    logic [3:0]  gout8, gout32;
    logic        busy8, done8, stall8, busy32, done32, stall32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_muldiv #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .aluop(aluop8), .funct(funct8), .valid_in(valid8),
        .a(a8), .b(b8), .gout(gout8), .busy(busy8), .done(done8), .stall(stall8),
        .hilo_out(hilo8), .hi(hi8), .lo(lo8)
    );

    alu_ctrl_muldiv #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .aluop(aluop32), .funct(funct32), .valid_in(valid32),
        .a(a32), .b(b32), .gout(gout32), .busy(busy32), .done(done32), .stall(stall32),
        .hilo_out(hilo32), .hi(hi32), .lo(lo32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_gout(input logic [2:0] op, input logic [5:0] fn);
        if (op == 3'b001) return 4'b0110;
        if (op == 3'b101) return 4'b0000;
        if (op == 3'b100) return 4'b0001;
        if (op == 3'b010) begin
            case (fn)
                6'b100010: return 4'b0110;
                6'b100100: return 4'b0000;
                6'b100101: return 4'b0001;
                6'b101010: return 4'b0111;
                6'b100111: return 4'b1100;
                default:   return 4'b0010;
            endcase
        end
        return 4'b0010;
    endfunction

    task automatic drive(input int w, input logic v, input logic [2:0] op, input logic [5:0] fn,
                         input logic [31:0] x, input logic [31:0] y);
        if (w == 8) begin
            valid8 = v; aluop8 = op; funct8 = fn; a8 = x[7:0]; b8 = y[7:0];
        end else begin
            valid32 = v; aluop32 = op; funct32 = fn; a32 = x; b32 = y;
        end
    endtask

    function automatic logic rd_done(input int w);
        return (w == 8) ? done8 : done32;
    endfunction

    function automatic logic rd_busy(input int w);
        return (w == 8) ? busy8 : busy32;
    endfunction

    function automatic logic [31:0] rd_hi(input int w);
        return (w == 8) ? {24'b0, hi8} : hi32;
    endfunction

    function automatic logic [31:0] rd_lo(input int w);
        return (w == 8) ? {24'b0, lo8} : lo32;
    endfunction

    function automatic logic [31:0] rd_hilo(input int w);
        return (w == 8) ? {24'b0, hilo8} : hilo32;
    endfunction

    function automatic logic rd_stall(input int w);
        return (w == 8) ? stall8 : stall32;
    endfunction

    // Issue one multu/divu, return edges from the sampling edge to done visible and busy cycles seen
    task automatic md(input int w, input logic isdiv, input logic [31:0] x, input logic [31:0] y,
                      output int lat, output int bc);
        @(negedge clk);
        drive(w, 1'b1, 3'b010, isdiv ? 6'b011011 : 6'b011001, x, y);
        @(posedge clk);
        lat = 1;
        bc  = 0;
        @(negedge clk);
        drive(w, 1'b0, 3'b000, 6'b100000, x, y);
        while (!rd_done(w) && lat < 100) begin
            if (rd_busy(w)) bc++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // Reference: plain arithmetic on masked operands
    task automatic expect_res(input int w, input logic isdiv, input logic [31:0] x, input logic [31:0] y,
                              output logic [31:0] ehi, output logic [31:0] elo);
        logic [63:0] mask, xm, ym, p;
        mask = (w == 8) ? 64'hFF : 64'hFFFF_FFFF;
        xm = {32'b0, x} & mask;
        ym = {32'b0, y} & mask;
        if (!isdiv) begin
            p   = xm * ym;
            elo = 32'(p & mask);
            ehi = 32'((p >> w) & mask);
        end else if (ym == 0) begin
            elo = 32'(mask);
            ehi = 32'(xm);
        end else begin
            elo = 32'(xm / ym);
            ehi = 32'(xm % ym);
        end
    endtask

    task automatic check_res(input string tag, input int w, input logic isdiv,
                             input logic [31:0] x, input logic [31:0] y, input int lat, input int bc);
        logic [31:0] ehi, elo;
        logic        z;
        expect_res(w, isdiv, x, y, ehi, elo);
        z = isdiv && (((w == 8) ? (y[7:0] == 8'h0) : (y == 32'h0)));
        chk({tag, "_lat"}, lat, z ? 1 : w + 1);
        chk({tag, "_busy"}, bc, z ? 0 : w);
        chk({tag, "_hi"}, rd_hi(w), ehi);
        chk({tag, "_lo"}, rd_lo(w), elo);
        drive(w, 1'b1, 3'b010, 6'b010010, 0, 0);
        #1;
        chk({tag, "_mflo_stall"}, rd_stall(w), 1'b0);
        chk({tag, "_mflo"}, rd_hilo(w), elo);
        @(negedge clk);
        drive(w, 1'b1, 3'b010, 6'b010000, 0, 0);
        #1;
        chk({tag, "_mfhi"}, rd_hilo(w), ehi);
        chk({tag, "_done_pulse"}, rd_done(w), 1'b0);
        drive(w, 1'b0, 3'b000, 6'b100000, 0, 0);
    endtask

    initial begin
        int lat, bc, n, seen, w;
        logic isdiv;
        logic [31:0] x, y;
        logic [2:0] op;
        logic [5:0] fn;
        logic [5:0] rfn [6];

        rfn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        reset = 1'b1;
        drive(8, 1'b1, 3'b010, 6'b010000, 8'h12, 8'h34);
        drive(32, 1'b1, 3'b010, 6'b011001, 32'h5, 32'h6);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_done8", done8, 1'b0);
        chk("rst_hi8", hi8, 8'h0);
        chk("rst_lo8", lo8, 8'h0);
        chk("rst_hilo8", hilo8, 8'h0);
        chk("rst_stall32", stall32, 1'b0);
        chk("rst_busy32", busy32, 1'b0);
        chk("rst_hilo32", hilo32, 32'h0);
        drive(8, 1'b0, 3'b000, 6'b100000, 0, 0);
        drive(32, 1'b0, 3'b000, 6'b100000, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // gout table sweep, then random opcode/funct pairs
        for (int i = 0; i < 8; i++) begin
            drive(8, 1'b0, 3'(i), 6'b100000, 0, 0);
            #1 chk($sformatf("gout_aluop%0d", i), gout8, exp_gout(3'(i), 6'b100000));
        end
        for (int i = 0; i < 6; i++) begin
            drive(8, 1'b0, 3'b010, rfn[i], 0, 0);
            #1 chk($sformatf("gout_funct%0h", rfn[i]), gout8, exp_gout(3'b010, rfn[i]));
        end
        drive(8, 1'b0, 3'b010, 6'b111111, 0, 0);
        #1 chk("gout_funct3f", gout8, 4'b0010);
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom);
            fn = ($urandom_range(0, 1) == 0) ? rfn[$urandom_range(0, 5)] : 6'($urandom);
            drive(32, 1'b0, op, fn, 0, 0);
            #1 chk("gout_rand", gout32, exp_gout(op, fn));
        end
        drive(8, 1'b0, 3'b000, 6'b100000, 0, 0);
        drive(32, 1'b0, 3'b000, 6'b100000, 0, 0);

        md(8, 1'b0, 32'hFF, 32'hFF, lat, bc);
        check_res("mul_ff", 8, 1'b0, 32'hFF, 32'hFF, lat, bc);

        md(32, 1'b1, 100, 7, lat, bc);
        check_res("div32_100_7", 32, 1'b1, 100, 7, lat, bc);
        md(32, 1'b1, 5, 0, lat, bc);
        check_res("div32_by0", 32, 1'b1, 5, 0, lat, bc);

        // Muldiv requests stall while busy; ordinary ALU ops do not
        @(negedge clk);
        drive(8, 1'b1, 3'b010, 6'b011001, 200, 13);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b1, 3'b010, 6'b010010, 0, 0);
        #1 chk("stall_mflo", stall8, 1'b1);
        @(negedge clk);
        drive(8, 1'b1, 3'b010, 6'b011001, 255, 255);
        #1 chk("stall_multu", stall8, 1'b1);
        @(negedge clk);
        drive(8, 1'b1, 3'b010, 6'b100000, 0, 0);
        #1 chk("nostall_add", stall8, 1'b0);
        chk("nostall_add_gout", gout8, 4'b0010);
        @(negedge clk);
        drive(8, 1'b0, 3'b000, 6'b100000, 0, 0);
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_done_seen", done8, 1'b1);
        chk("stall_hi", hi8, 8'h0A);
        chk("stall_lo", lo8, 8'h28);
        drive(8, 1'b1, 3'b010, 6'b010010, 0, 0);
        #1 chk("stall_mflo_done", hilo8, 8'h28);
        chk("stall_mflo_done_nostall", stall8, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 3'b000, 6'b100000, 0, 0);

        // Back-to-back: divu accepted in the done cycle of a multu
        md(8, 1'b0, 200, 3, lat, bc);
        chk("b2b_mul_lat", lat, 9);
        chk("b2b_mul_hi", hi8, 8'h02);
        chk("b2b_mul_lo", lo8, 8'h58);
        drive(8, 1'b1, 3'b010, 6'b011011, 250, 9);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 3'b000, 6'b100000, 0, 0);
        chk("b2b_busy", busy8, 1'b1);
        chk("b2b_done_low", done8, 1'b0);
        lat = 1;
        while (!done8 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("b2b_div_lat", lat, 9);
        chk("b2b_div_hi", hi8, 8'd7);
        chk("b2b_div_lo", lo8, 8'd27);
        @(negedge clk);

        // Reset mid-RUN aborts with no done pulse
        drive(8, 1'b1, 3'b010, 6'b011001, 8'h35, 8'h47);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 3'b000, 6'b100000, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_mid_busy_before", busy8, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", busy8, 1'b0);
        chk("rst_mid_hi", hi8, 8'h0);
        chk("rst_mid_lo", lo8, 8'h0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen = 1;
        end
        chk("rst_mid_no_done", seen, 0);
        md(8, 1'b0, 8'h35, 8'h47, lat, bc);
        check_res("rst_fresh_mul", 8, 1'b0, 8'h35, 8'h47, lat, bc);

        // Randomized operations against the reference
        for (int i = 0; i < 24; i++) begin
            w     = (i % 4 == 3) ? 32 : 8;
            isdiv = 1'($urandom_range(0, 1));
            x     = $urandom;
            y     = ($urandom_range(0, 5) == 0) ? 32'h0 :
                    ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            md(w, isdiv, x, y, lat, bc);
            check_res($sformatf("rand%0d", i), w, isdiv, x, y, lat, bc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
